alu_bit_8: RTL and testbench

- 8-bit registered ALU: two unsigned 8-bit operands, 3-bit opcode, 16-bit result, 8 operations (add, sub, mul, shl, shr, and, or, xor).
- Sits in the datapath as a single-cycle-latency execute stage with a valid qualifier, so upstream logic can issue one operation per clock.

---
 rtl/alu_bit_8.sv | 66 ++++++
 tb/tb_alu_bit_8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_8.sv
// Registered 8-bit ALU execute stage: eight unsigned operations, 16-bit result,
// one clock of latency with a valid qualifier and a registered zero flag.
module alu_bit_8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  InputA,
   input  logic [7:0]  InputB,
   input  logic [2:0]  OpCode,
   output logic        out_valid,
   output logic [15:0] OutALU,
   output logic        zero
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_SHL = 3'b011,
      OP_SHR = 3'b100,
      OP_AND = 3'b101,
      OP_OR  = 3'b110,
      OP_XOR = 3'b111
   } op_e;

   logic [15:0] a_ext;
   logic [15:0] b_ext;
   logic [15:0] result;
   op_e         op;

   assign a_ext = {8'h00, InputA};
   assign b_ext = {8'h00, InputB};
   assign op    = op_e'(OpCode);

   // NOTE: result gets a value before the case so no path leaves it unassigned (no latch).
   always_comb begin
      result = '0;
      case (op)
         OP_ADD: result = a_ext + b_ext;
         OP_SUB: result = a_ext - b_ext;
         OP_MUL: result = a_ext * b_ext;
         // Shift amounts past the result width flush to zero rather than wrapping.
         OP_SHL: result = (InputB >= 8'd16) ? 16'h0000 : (a_ext << InputB[3:0]);
         OP_SHR: result = (InputB >= 8'd8)  ? 16'h0000 : (a_ext >> InputB[2:0]);
         OP_AND: result = a_ext & b_ext;
         OP_OR:  result = a_ext | b_ext;
         OP_XOR: result = a_ext ^ b_ext;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         OutALU    <= 16'h0000;
         zero      <= 1'b1;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            OutALU <= result;
            zero   <= (result == 16'h0000);
         end
      end
   end

endmodule

// File: tb/tb_alu_bit_8.sv
// Self-checking bench for alu_bit_8: directed literal checks plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_bit_8;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  InputA;
   logic [7:0]  InputB;
   logic [2:0]  OpCode;
   logic        out_valid;
   logic [15:0] OutALU;
   logic        zero;

   int n_vec;
   int n_bad;
   bit model_on;

   alu_bit_8 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .InputA   (InputA),
      .InputB   (InputB),
      .OpCode   (OpCode),
      .out_valid(out_valid),
      .OutALU   (OutALU),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, shifts as multiply/divide by powers of two.
   function automatic logic [15:0] ref_f(input int a, input int b, input int op);
      int r;
      r = 0;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a * b;
         3: r = (b >= 16) ? 0 : a * (1 << b);
         4: r = (b >= 8) ? 0 : a / (1 << b);
         5: r = a & b;
         6: r = a | b;
         default: r = a ^ b;
      endcase
      return 16'(r & 32'hFFFF);
   endfunction

   logic        m_valid;
   logic [15:0] m_out;
   logic        m_zero;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_out   <= 16'h0000;
         m_zero  <= 1'b1;
      end else begin
         m_valid <= in_valid;
         if (in_valid) begin
            m_out  <= ref_f(int'(InputA), int'(InputB), int'(OpCode));
            m_zero <= (ref_f(int'(InputA), int'(InputB), int'(OpCode)) == 16'h0000);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         check("model out_valid", {15'h0, out_valid}, {15'h0, m_valid});
         check("model OutALU", OutALU, m_out);
         check("model zero", {15'h0, zero}, {15'h0, m_zero});
      end
   end

   // Drive at a falling edge, let one rising edge capture, return at the next falling edge.
   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      in_valid = v;
      InputA   = a;
      InputB   = b;
      OpCode   = op;
      @(negedge clk);
   endtask

   task automatic pin(input string name, input logic [15:0] exp);
      check({name, " OutALU"}, OutALU, exp);
      check({name, " zero"}, {15'h0, zero}, {15'h0, (exp == 16'h0000)});
      check({name, " out_valid"}, {15'h0, out_valid}, 16'h0001);
   endtask

   task automatic check_reset(input string name);
      check({name, " OutALU"}, OutALU, 16'h0000);
      check({name, " zero"}, {15'h0, zero}, 16'h0001);
      check({name, " out_valid"}, {15'h0, out_valid}, 16'h0000);
   endtask

   logic [15:0] basic_exp [8];
   logic [15:0] held;

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      model_on = 1'b0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      InputA   = '0;
      InputB   = '0;
      OpCode   = '0;
      basic_exp = '{16'h0012, 16'h000C, 16'h002D, 16'h0078,
                    16'h0001, 16'h0003, 16'h000F, 16'h000C};

      repeat (2) @(negedge clk);
      check_reset("power-on reset");
      rst_n    = 1'b1;
      model_on = 1'b1;

      // Model pins: hand-computed results, independent of the reference function.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 8'h0F, 8'h03, 3'(k));
         pin($sformatf("basic op%0d", k), basic_exp[k]);
      end

      step(1'b1, 8'hFF, 8'hFF, 3'b000); pin("ff add", 16'h01FE);
      step(1'b1, 8'hFF, 8'hFF, 3'b010); pin("ff mul", 16'hFE01);
      step(1'b1, 8'hFF, 8'hFF, 3'b111); pin("ff xor", 16'h0000);
      step(1'b1, 8'h03, 8'h0F, 3'b001); pin("sub wrap", 16'hFFF4);
      step(1'b1, 8'h81, 8'd7,  3'b011); pin("shl 7", 16'h4080);
      step(1'b1, 8'h81, 8'd8,  3'b011); pin("shl 8", 16'h8100);
      step(1'b1, 8'h81, 8'd16, 3'b011); pin("shl 16", 16'h0000);
      step(1'b1, 8'h81, 8'd8,  3'b100); pin("shr 8", 16'h0000);
      step(1'b1, 8'h81, 8'd1,  3'b100); pin("shr 1", 16'h0040);

      // Idle cycles with toggling inputs must not disturb the held result.
      held = 16'h0040;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
         check("idle OutALU hold", OutALU, held);
         check("idle zero hold", {15'h0, zero}, 16'h0000);
         check("idle out_valid", {15'h0, out_valid}, 16'h0000);
      end

      // Mid-stream async reset between edges: clears at once, pending op discarded.
      in_valid = 1'b1;
      InputA   = 8'h22;
      InputB   = 8'h11;
      OpCode   = 3'b000;
      #2 rst_n = 1'b0;
      #1 check_reset("async reset immediate");
      @(negedge clk);
      check_reset("reset held across edge");
      rst_n = 1'b1;
      step(1'b1, 8'h22, 8'h11, 3'b110); pin("first after reset", 16'h0033);

      // Randomized traffic; shift opcodes get small shift amounts half the time.
      for (int k = 0; k < 3000; k++) begin
         logic [2:0] op;
         logic [7:0] b;
         op = 3'($urandom);
         b  = 8'($urandom);
         if ((op == 3'b011 || op == 3'b100) && $urandom_range(0, 1) == 0)
            b = 8'($urandom_range(0, 20));
         step(($urandom_range(0, 3) != 0), 8'($urandom), b, op);
         if (k == 1500) begin
            #3 rst_n = 1'b0;
            #1 check_reset("random-phase reset");
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      step(1'b0, 8'h00, 8'h00, 3'b000);
      model_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
